// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the register file, ALU,
// write-back mux and control decoder.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_rport.sv
// One combinational read port of the register file.
// Ports: rst_n, ra (address), stored (mem[ra]), we/wa/wd
// (write in flight, used for bypass), rd (read data).
module reg_file_rport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] stored,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    logic hit;

    // wa == ra with ra != 0 implies wa != 0, so the zero
    // check below also keeps writes to r0 from bypassing.
    assign hit = BYPASS && we && (wa == ra);

    always_comb begin
        rd = '0;
        if (!rst_n || ra == '0) begin
            rd = '0;
        end else if (hit) begin
            rd = wd;
        end else begin
            rd = stored;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 general-purpose register file, r0 hardwired to 0.
// Ports: clk, rst_n, ra1/rd1, ra2/rd2, we/wa/wd, dbg_ra/dbg_rd,
// wr_cnt (committed writes since reset).
module reg_file #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] dbg_ra,
    output logic [DATA_W-1:0] dbg_rd,
    output logic [31:0]       wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              commit;

    // r0 is never written, so its entry stays at reset value.
    assign commit = we && (wa != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_cnt <= '0;
        end else if (commit) begin
            mem[wa] <= wd;
            wr_cnt  <= wr_cnt + 32'd1;
        end
    end

    reg_file_rport #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .BYPASS(BYPASS)
    ) u_rport1 (
        .rst_n  (rst_n),
        .ra     (ra1),
        .stored (mem[ra1]),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .rd     (rd1)
    );

    reg_file_rport #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .BYPASS(BYPASS)
    ) u_rport2 (
        .rst_n  (rst_n),
        .ra     (ra2),
        .stored (mem[ra2]),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .rd     (rd2)
    );

    // Debug port shows committed state only.
    reg_file_rport #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .BYPASS(1'b0)
    ) u_rport_dbg (
        .rst_n  (rst_n),
        .ra     (dbg_ra),
        .stored (mem[dbg_ra]),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .rd     (dbg_rd)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed steps plus
// random traffic compared against an array-based model.
module tb_reg_file;
    import cpu_pkg::*;

    localparam bit BYP = 1'b1;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa, dbg_ra;
    logic [31:0] rd1, rd2, wd, dbg_rd, wr_cnt;
    logic        we;

    int checks;
    int errors;

    logic [31:0] ref_mem [NUM_REGS];
    logic [31:0] ref_cnt;
    logic        ref_rst;

    reg_file #(
        .DATA_W(32),
        .ADDR_W(5),
        .BYPASS(BYP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra1    (ra1),
        .rd1    (rd1),
        .ra2    (ra2),
        .rd2    (rd2),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .dbg_ra (dbg_ra),
        .dbg_rd (dbg_rd),
        .wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) ref_mem[i] = '0;
        ref_cnt = '0;
    endtask

    // Expected read value for a port, before the next edge.
    function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                           input bit byp);
        if (ref_rst) return '0;
        if (a == 5'd0) return '0;
        if (byp && we && wa == a) return wd;
        return ref_mem[a];
    endfunction

    // Apply one clock edge and update the model.
    task automatic edge_step();
        @(posedge clk);
        if (rst_n && we && wa != 5'd0) begin
            ref_mem[wa] = wd;
            ref_cnt     = ref_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        edge_step();
        we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ref_rst = 1'b1;
        model_reset();
        #3;
        rst_n   = 1'b1;
        ref_rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        ref_rst = 1'b1;
        we      = 1'b0;
        wa      = '0;
        wd      = '0;
        ra1     = '0;
        ra2     = '0;
        dbg_ra  = '0;
        model_reset();

        // Reset state
        #2;
        ra1 = 5'd4;
        #1;
        check("rst_rd1", rd1, 32'd0);
        check("rst_cnt", wr_cnt, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ref_rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: async reset clears without a clock
        wr(5'd5, 32'hDEAD_BEEF);
        dbg_ra = 5'd5;
        #1;
        check("t1_pre", dbg_rd, 32'hDEAD_BEEF);
        check("t1_cnt_pre", wr_cnt, 32'd1);
        #1;
        rst_n   = 1'b0;
        ref_rst = 1'b1;
        model_reset();
        #1;
        check("t1_dbg", dbg_rd, 32'd0);
        check("t1_cnt", wr_cnt, 32'd0);
        #2;
        rst_n   = 1'b1;
        ref_rst = 1'b0;
        @(posedge clk);
        #1;

        // 2: basic write then read
        wr(5'd8, 32'h1234_5678);
        ra1 = 5'd8;
        ra2 = 5'd8;
        #1;
        check("t2_rd1", rd1, 32'h1234_5678);
        check("t2_rd2", rd2, 32'h1234_5678);
        check("t2_cnt", wr_cnt, 32'd1);

        // 3: r0 protected, even with write pending
        we     = 1'b1;
        wa     = 5'd0;
        wd     = 32'hFFFF_FFFF;
        ra1    = 5'd0;
        dbg_ra = 5'd0;
        #1;
        check("t3_pend", rd1, 32'd0);
        edge_step();
        we = 1'b0;
        check("t3_rd1", rd1, 32'd0);
        check("t3_dbg", dbg_rd, 32'd0);
        check("t3_cnt", wr_cnt, 32'd1);

        // 4: bypass vs stored value
        wr(5'd3, 32'hAAAA_0000);
        we     = 1'b1;
        wa     = 5'd3;
        wd     = 32'h5555_1111;
        ra1    = 5'd3;
        dbg_ra = 5'd3;
        #1;
        check("t4_rd1_pre", rd1,
              BYP ? 32'h5555_1111 : 32'hAAAA_0000);
        check("t4_dbg_pre", dbg_rd, 32'hAAAA_0000);
        edge_step();
        we = 1'b0;
        check("t4_rd1_post", rd1, 32'h5555_1111);
        check("t4_dbg_post", dbg_rd, 32'h5555_1111);

        // 5: full sweep after a fresh reset
        do_reset();
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'h100 + 32'(i));
        end
        for (int i = 1; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(32 - i);
            #1;
            check("t5_rd1", rd1, 32'h100 + 32'(i));
            check("t5_rd2", rd2, 32'h100 + 32'(32 - i));
        end
        check("t5_cnt", wr_cnt, 32'd31);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            we     = 1'($urandom_range(0, 1));
            wa     = 5'($urandom_range(0, 31));
            wd     = $urandom;
            ra1    = 5'($urandom_range(0, 31));
            ra2    = ($urandom_range(0, 3) == 0) ? ra1 :
                     5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ra1 = wa;
            dbg_ra = 5'($urandom_range(0, 31));
            #1;
            check("rnd_rd1", rd1, exp_rd(ra1, BYP));
            check("rnd_rd2", rd2, exp_rd(ra2, BYP));
            check("rnd_dbg", dbg_rd, exp_rd(dbg_ra, 1'b0));
            edge_step();
            check("rnd_cnt", wr_cnt, ref_cnt);
        end
        we = 1'b0;

        // 6: reset held across a write edge
        wr(5'd7, 32'h0000_0042);
        we     = 1'b1;
        wa     = 5'd7;
        wd     = 32'h77;
        ra1    = 5'd7;
        dbg_ra = 5'd7;
        #1;
        rst_n   = 1'b0;
        ref_rst = 1'b1;
        model_reset();
        #1;
        check("t6_rd1_rst", rd1, 32'd0);
        edge_step();
        we = 1'b0;
        #1;
        rst_n   = 1'b1;
        ref_rst = 1'b0;
        #1;
        check("t6_dbg", dbg_rd, 32'd0);
        check("t6_cnt", wr_cnt, 32'd0);
        check("t6_model", dbg_rd, ref_mem[7]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry × 32-bit general-purpose register file for the single-cycle CPU.
- Sits directly downstream of the 32-bit write-back mux, which selects between ALU result and memory load data.
- Consumes the mux output as write data on the clock edge.
- Supplies both source operands to the ALU operand muxes combinationally within the same cycle.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = a read returns the same-cycle write data on an address match; 0 = a read returns the stored value

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ra1  in  ADDR_W  read address, port 1 (rs)
- rd1  out  DATA_W  read data, port 1
- ra2  in  ADDR_W  read address, port 2 (rt)
- rd2  out  DATA_W  read data, port 2
- we  in  1  write enable (RegWrite from control)
- wa  in  ADDR_W  write address (from RegDst mux)
- wd  in  DATA_W  write data (from write-back 32-bit mux)
- dbg_ra  in  ADDR_W  debug/bench read address
- dbg_rd  out  DATA_W  debug read data; never bypassed
- wr_cnt  out  32  count of committed writes since reset, wraps at 2**32

Behaviour:
- Reset:
  - One clock, clk; reset is asynchronous and active-low on rst_n.
  - On rst_n falling, all registers clear to 0 and wr_cnt clears to 0 immediately, with no clock needed.
  - While rst_n = 0, all read outputs = 0 and no write commits.
  - Reset asserted during a write cycle: reset wins and the write is lost.
- Write:
  - At a rising edge of clk with rst_n = 1, we = 1 and wa != 0: mem[wa] <= wd, and wr_cnt <= wr_cnt + 1.
  - wa = 0 with we = 1: no state change and wr_cnt is not incremented. Register 0 is hardwired to zero.
  - we = 0: no state change.
- Read:
  - rd1, rd2 and dbg_rd are combinational from the addresses, with zero-cycle latency.
  - Any read of address 0 returns 0 regardless of a pending write.
  - BYPASS = 1: if we = 1, wa = raN and wa != 0, then rdN = wd in the same cycle, before the edge.
  - BYPASS = 0: rdN = mem[raN]; the new value is visible after the edge.
  - ra1 = ra2 is legal; both ports return identical data.
  - dbg_rd always returns the stored value (mem[dbg_ra]), ignoring any write in flight.
- Width rules:
  - wd is stored unmodified. No sign handling is done here.
  - wr_cnt wraps from 0xFFFF_FFFF to 0 silently.
- Inputs: X/Z on addresses is not permitted in normal operation. The bench flags X on any read output while rst_n = 1.

Decomposition:
- cpu_pkg holds DATA_W = 32, REG_ADDR_W = 5, NUM_REGS = 32 and REG_ZERO = 5'd0.
- The ALU, write-back mux and control decoder share these constants.
- One sub-module is natural: reg_file_rport, a single read port with zero-check and optional bypass. It is instantiated twice (rd1, rd2) and once with bypass forced off (dbg_rd).
- Storage and wr_cnt live in the top.

Test Plan:
1. Reset clears all registers: pulse rst_n low mid-cycle after writing 0xDEADBEEF to r5 -> dbg_rd (r5) = 0 and wr_cnt = 0 immediately, without a clock edge.
2. Basic write then read: we = 1, wa = 8, wd = 0x1234_5678, one edge; then ra1 = 8, ra2 = 8 -> rd1 = rd2 = 0x1234_5678; wr_cnt = 1.
3. Register 0 protection: we = 1, wa = 0, wd = 0xFFFF_FFFF, edge; ra1 = 0 -> rd1 = 0, dbg_rd (r0) = 0, wr_cnt unchanged.
4. Bypass: r3 = 0xAAAA_0000 stored; same cycle drive we = 1, wa = 3, wd = 0x5555_1111, ra1 = 3 -> BYPASS = 1 gives rd1 = 0x5555_1111 before the edge; BYPASS = 0 gives 0xAAAA_0000 before and 0x5555_1111 after. dbg_rd (r3) = 0xAAAA_0000 before the edge in both builds.
5. Full sweep: write r1..r31 with value 0x100 + i on consecutive edges, then read every pair (i, 32 − i) -> both ports match; wr_cnt = 31.
6. Reset during write: we = 1, wa = 7, wd = 0x77, with rst_n driven low across the edge -> r7 = 0 and wr_cnt = 0 after rst_n is released.
